potential_port_arb: RTL and testbench
=====================================

# potential_port_arb

Parametrised shared-port controller for a spiking-cluster potential memory. It owns the potential RAM (one read port, one write port) and arbitrates NUM_REQ requesters (host, PEs, scheduler) independently on each port with round-robin fairness. Read data goes out on a shared bus with a per-requester valid strobe, and same-cycle read/write to one address is bypassed. It generalises the fixed 6-way arbiter, potential wrapper and read-grant steering currently inside the cluster, and adds a saturating contention counter.

## Interface
- NUM_REQ, 6, number of requesters; index 0 = host, 1..NUM_REQ-2 = PEs, NUM_REQ-1 = scheduler
- DATA_W, 384, potential word width (POTENTIAL_WIDTH*K_L)
- DEPTH, 128, potential words
- ADDR_W, $clog2(DEPTH), address width
- CNT_W, 16, contention counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- rd_req  in  NUM_REQ  read request per requester, held until granted
- rd_addr  in  NUM_REQ*ADDR_W  read addresses, requester r at bits [r*ADDR_W +: ADDR_W]
- rd_grant  out  NUM_REQ  one-hot read grant (combinational)
- rd_valid  out  NUM_REQ  one-hot: rd_data belongs to this requester
- rd_data  out  DATA_W  shared registered read data
- wr_req  in  NUM_REQ  write request per requester
- wr_addr  in  NUM_REQ*ADDR_W  write addresses, packed as rd_addr
- wr_data  in  NUM_REQ*DATA_W  write data, requester r at [r*DATA_W +: DATA_W]
- wr_grant  out  NUM_REQ  one-hot write grant (combinational)
- cnt_clr  in  1  synchronous clear of contention counter
- contention_cnt  out  CNT_W  cycles with ≥2 simultaneous read or write requests

## Operation
- Two independent round-robin arbiters, one per port. Each has a registered pointer rr_ptr (0..NUM_REQ-1).
- Grant is combinational: the first asserted req at index rr_ptr, rr_ptr+1, … with modulo-NUM_REQ wrap-around. At most one grant bit is set. Grant is all-zero when req is all-zero or rst is low.
- On a granted cycle, rr_ptr <= (granted index + 1) mod NUM_REQ. With no request, rr_ptr holds.
- Write: a granted write commits mem[wr_addr[g]] <= wr_data[g] at that clock edge.
- Read: a granted read registers mem[rd_addr[g]] into rd_data. rd_valid <= one-hot(g) on the same edge.
- Bypass: a same-cycle granted read and write to an equal address return the new write data (write-first).
- With no read grant: rd_valid <= 0 and rd_data holds its previous value.
- Requesters keep req/addr/data stable until they see their grant. Dropping req before grant is legal and loses the slot.
- Contention counter:
  - Increments by 1 in any cycle where popcount(rd_req) ≥ 2 or popcount(wr_req) ≥ 2.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment.
- Memory contents are not reset. Reading an unwritten address returns X in simulation; the bench must not check it.

## Timing
- Reset values:
  - rd_valid = 0, rd_data = 0, contention_cnt = 0.
  - Both rr_ptr = 0.
  - rd_grant = wr_grant = 0 for as long as rst is low.
- Read latency: rd_req asserted in cycle N with grant in cycle N gives rd_valid and rd_data in cycle N+1, for exactly one cycle.
- Back-to-back grants to different requesters give consecutive rd_valid pulses, one per cycle.
- Write latency: data is visible to a non-bypassed read granted in cycle N+1.
- Worst-case wait for a continuously requesting requester is NUM_REQ-1 cycles.
- Reset mid-operation clears any pending rd_valid immediately (asynchronous). After rst deasserts, arbitration restarts at index 0.

## Test plan
- Reset: hold rst low with all req=1 -> grants 0, rd_valid 0, rd_data 0, contention_cnt 0.
- Single write/read: requester 2 writes 0xA5 to addr 7 in cycle 1; requester 4 reads addr 7 in cycle 2 -> cycle 3 rd_valid=6'b010000, rd_data=0xA5.
- Round-robin: rd_req=6'b111111 held 12 cycles -> grants cycle through indices 0,1,2,3,4,5,0,…; rd_valid is the same sequence delayed by one cycle; contention_cnt=12.
- Wrap/skip: rr_ptr=5 with rd_req=6'b000101 -> grant index 0, then 2, then 0.
- Bypass: same cycle, write 0x1234 to addr 3 by requester 1 and read addr 3 by requester 5 -> next cycle rd_data=0x1234, rd_valid=6'b100000.
- Saturation and clear: CNT_W=4 with constant contention for 20 cycles -> contention_cnt=15; assert cnt_clr together with contention -> 0 on the next cycle.

Source files
------------

// File: rtl/potential_port_if.sv
// Requester-side bundle for the shared potential memory: read and write
// request/grant handshakes plus the shared registered read-data bus.
interface potential_port_if #(
    parameter int NUM_REQ = 6,
    parameter int DATA_W  = 384,
    parameter int ADDR_W  = 7
);
    logic [NUM_REQ-1:0]        rd_req;
    logic [NUM_REQ*ADDR_W-1:0] rd_addr;
    logic [NUM_REQ-1:0]        rd_grant;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_grant;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_grant, rd_valid, rd_data, wr_grant
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_grant, rd_valid, rd_data, wr_grant
    );
endinterface

// File: rtl/potential_port_arb.sv
// Potential RAM owner with independent round-robin arbitration of the read and
// write ports, write-first bypass and a saturating contention counter.
module potential_port_arb #(
    parameter int NUM_REQ = 6,
    parameter int DATA_W  = 384,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    potential_port_if.slave      bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     contention_cnt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [NUM_REQ-1:0] rd_grant_s;
    logic [NUM_REQ-1:0] wr_grant_s;
    logic [PTR_W-1:0]   rd_idx_s;
    logic [PTR_W-1:0]   wr_idx_s;
    logic               rd_any_s;
    logic               wr_any_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [ADDR_W-1:0]  wr_addr_s;
    logic [DATA_W-1:0]  wr_data_s;
    logic [DATA_W-1:0]  rd_word_s;
    logic               contention_s;
    logic [NUM_REQ-1:0] rd_valid_r;
    logic [DATA_W-1:0]  rd_data_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  mem [DEPTH];

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [NUM_REQ-1:0] gnt;
        logic               found;
        logic [PTR_W-1:0]   idx;
        gnt   = {NUM_REQ{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = idx | (oh[i] ? PTR_W'(i) : {PTR_W{1'b0}});
        end
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : idx + PTR_W'(1);
    endfunction

    // Combinational grants, port steering and write-first bypass.
    always_comb begin
        rd_grant_s = {NUM_REQ{1'b0}};
        wr_grant_s = {NUM_REQ{1'b0}};
        if (rst) begin
            rd_grant_s = rr_pick(bus.rd_req, rd_ptr_r);
            wr_grant_s = rr_pick(bus.wr_req, wr_ptr_r);
        end else begin
            rd_grant_s = {NUM_REQ{1'b0}};
            wr_grant_s = {NUM_REQ{1'b0}};
        end
        rd_any_s  = |rd_grant_s;
        wr_any_s  = |wr_grant_s;
        rd_idx_s  = oh_to_idx(rd_grant_s);
        wr_idx_s  = oh_to_idx(wr_grant_s);
        rd_addr_s = bus.rd_addr[rd_idx_s*ADDR_W +: ADDR_W];
        wr_addr_s = bus.wr_addr[wr_idx_s*ADDR_W +: ADDR_W];
        wr_data_s = bus.wr_data[wr_idx_s*DATA_W +: DATA_W];
        if (wr_any_s && (wr_addr_s == rd_addr_s)) begin
            rd_word_s = wr_data_s;
        end else begin
            rd_word_s = mem[rd_addr_s];
        end
        // Two or more set bits: clearing the lowest one leaves something behind.
        contention_s = (|(bus.rd_req & (bus.rd_req - NUM_REQ'(1)))) ||
                       (|(bus.wr_req & (bus.wr_req - NUM_REQ'(1))));
    end

    // Round-robin pointers move just past the requester that was served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (rd_any_s) rd_ptr_r <= next_ptr(rd_idx_s);
            if (wr_any_s) wr_ptr_r <= next_ptr(wr_idx_s);
        end
    end

    // Potential storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_any_s) mem[wr_addr_s] <= wr_data_s;
    end

    // Registered read return; data holds when nobody is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_r <= {NUM_REQ{1'b0}};
            rd_data_r  <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= rd_grant_s;
            if (rd_any_s) rd_data_r <= rd_word_s;
        end
    end

    // Saturating contention counter, clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (contention_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bus.rd_grant    = rd_grant_s;
    assign bus.wr_grant    = wr_grant_s;
    assign bus.rd_valid    = rd_valid_r;
    assign bus.rd_data     = rd_data_r;
    assign contention_cnt  = cnt_r;
endmodule

// File: tb/tb_potential_port_arb.sv
// Directed checks of the arbiter plus a randomized run scored against a
// queue of expected read returns produced by a behavioural model.
module tb_potential_port_arb;
    localparam int N  = 6;
    localparam int DW = 384;
    localparam int DP = 128;
    localparam int AW = 7;
    localparam int CW = 4;
    localparam int CMAX = 15;

    typedef struct {
        logic [N-1:0]  oh;
        logic [DW-1:0] data;
        bit            known;
        int            stamp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] contention_cnt;

    potential_port_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    potential_port_arb #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr), .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [DW-1:0] mon_last;
    bit mon_known = 1'b0;
    exp_t sb[$];

    logic          rq [N];
    logic          wq [N];
    logic [AW-1:0] ra [N];
    logic [AW-1:0] wa [N];
    logic [DW-1:0] wd [N];

    logic [DW-1:0] m_mem [int];
    int m_prd, m_pwr, m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply();
        for (int r = 0; r < N; r++) begin
            bus.rd_req[r]             = rq[r];
            bus.wr_req[r]             = wq[r];
            bus.rd_addr[r*AW +: AW]   = ra[r];
            bus.wr_addr[r*AW +: AW]   = wa[r];
            bus.wr_data[r*DW +: DW]   = wd[r];
        end
    endtask

    task automatic idle();
        for (int r = 0; r < N; r++) begin
            rq[r] = 1'b0;
            wq[r] = 1'b0;
        end
        apply();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cnt_clr = 1'b0;
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Index served when scanning upward from ptr with wrap; -1 when nobody asks.
    function automatic int pick(input logic v [N], input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int count_set(input logic v [N]);
        int c = 0;
        for (int k = 0; k < N; k++) c += (v[k] ? 1 : 0);
        return c;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] o = '0;
        if (g >= 0) o[g] = 1'b1;
        return o;
    endfunction

    // Monitor: consumes one expected return per rd_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #2;
            if (mon_en) begin
                if (bus.rd_valid != '0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_valid_unexpected actual=%0h required=0", bus.rd_valid);
                    end else begin
                        e = sb.pop_front();
                        check("rd_valid", DW'(bus.rd_valid), DW'(e.oh));
                        check("rd_latency", DW'(cyc - 1), DW'(e.stamp));
                        if (e.known) check("rd_data", bus.rd_data, e.data);
                        mon_last  = e.data;
                        mon_known = e.known;
                    end
                end else if (mon_known) begin
                    check("rd_data_hold", bus.rd_data, mon_last);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] wrap_exp [3];
        int gr, gw, ci;
        exp_t e;
        wrap_exp[0] = 6'b000001;
        wrap_exp[1] = 6'b000100;
        wrap_exp[2] = 6'b000001;
        for (int r = 0; r < N; r++) begin
            rq[r] = 1'b1; wq[r] = 1'b1;
            ra[r] = '0; wa[r] = '0; wd[r] = '0;
        end
        apply();

        // Held in reset with everyone requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_grant", DW'(bus.rd_grant), DW'(0));
        check("reset_wr_grant", DW'(bus.wr_grant), DW'(0));
        check("reset_rd_valid", DW'(bus.rd_valid), DW'(0));
        check("reset_rd_data", bus.rd_data, DW'(0));
        check("reset_cnt", DW'(contention_cnt), DW'(0));

        // Round-robin over all six readers.
        do_reset();
        for (int r = 0; r < N; r++) rq[r] = 1'b1;
        apply();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rr_grant", DW'(bus.rd_grant), DW'(onehot(i % N)));
            @(posedge clk); #1;
            check("rr_valid", DW'(bus.rd_valid), DW'(onehot(i % N)));
        end
        idle();
        check("rr_cnt", DW'(contention_cnt), DW'(12));

        // Move the pointer to 5, then wrap and skip idle requesters.
        rq[4] = 1'b1;
        apply();
        @(negedge clk);
        check("wrap_setup", DW'(bus.rd_grant), DW'(6'b010000));
        @(posedge clk); #1;
        rq[4] = 1'b0; rq[0] = 1'b1; rq[2] = 1'b1;
        apply();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrap_grant", DW'(bus.rd_grant), DW'(wrap_exp[i]));
            @(posedge clk); #1;
        end
        idle();

        // Write by requester 2, read back by requester 4.
        do_reset();
        wq[2] = 1'b1; wa[2] = 7'd7; wd[2] = DW'(8'hA5);
        apply();
        @(negedge clk);
        check("wr_grant", DW'(bus.wr_grant), DW'(6'b000100));
        @(posedge clk); #1;
        wq[2] = 1'b0; rq[4] = 1'b1; ra[4] = 7'd7;
        apply();
        @(negedge clk);
        check("rd_grant", DW'(bus.rd_grant), DW'(6'b010000));
        @(posedge clk); #1;
        check("wr_rd_valid", DW'(bus.rd_valid), DW'(6'b010000));
        check("wr_rd_data", bus.rd_data, DW'(8'hA5));

        // Same-cycle write and read of one address.
        rq[4] = 1'b0;
        wq[1] = 1'b1; wa[1] = 7'd3; wd[1] = DW'(16'h1234);
        rq[5] = 1'b1; ra[5] = 7'd3;
        apply();
        @(posedge clk); #1;
        check("bypass_valid", DW'(bus.rd_valid), DW'(6'b100000));
        check("bypass_data", bus.rd_data, DW'(16'h1234));
        idle();
        @(posedge clk); #1;
        check("hold_valid", DW'(bus.rd_valid), DW'(0));
        check("hold_data", bus.rd_data, DW'(16'h1234));

        // Reset landing on a pending read return.
        rq[0] = 1'b1; ra[0] = 7'd3;
        apply();
        @(posedge clk); #1;
        check("pre_reset_valid", DW'(bus.rd_valid), DW'(6'b000001));
        check("pre_reset_data", bus.rd_data, DW'(16'h1234));
        #1 rst = 1'b0;
        #1;
        check("async_rd_valid", DW'(bus.rd_valid), DW'(0));
        check("async_rd_grant", DW'(bus.rd_grant), DW'(0));
        check("async_rd_data", bus.rd_data, DW'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        rq[5] = 1'b1;
        apply();
        @(negedge clk);
        check("restart_grant", DW'(bus.rd_grant), DW'(6'b000001));
        @(posedge clk); #1;
        idle();

        // Saturation and clear priority.
        do_reset();
        rq[0] = 1'b1; rq[1] = 1'b1;
        apply();
        repeat (20) @(posedge clk);
        #1;
        check("sat_cnt", DW'(contention_cnt), DW'(CMAX));
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        check("clr_cnt", DW'(contention_cnt), DW'(0));
        cnt_clr = 1'b0;
        @(posedge clk); #1;
        check("after_clr_cnt", DW'(contention_cnt), DW'(1));
        idle();
        wq[0] = 1'b1; wq[1] = 1'b1;
        apply();
        @(posedge clk); #1;
        check("wr_contention_cnt", DW'(contention_cnt), DW'(2));
        idle();

        // Randomized traffic against the behavioural model.
        do_reset();
        m_prd = 0; m_pwr = 0; m_cnt = 0;
        mon_last = '0; mon_known = 1'b1;
        sb.delete();
        mon_en = 1'b1;
        gr = -1; gw = -1;
        for (int n = 0; n < 2000; n++) begin
            for (int r = 0; r < N; r++) begin
                if (!(rq[r] && r != gr && $urandom_range(0, 19) != 0)) begin
                    rq[r] = ($urandom_range(0, 2) == 0);
                    ra[r] = AW'($urandom_range(0, 15));
                end
                if (!(wq[r] && r != gw && $urandom_range(0, 19) != 0)) begin
                    wq[r] = ($urandom_range(0, 3) == 0);
                    wa[r] = AW'($urandom_range(0, 15));
                    wd[r] = rand_word();
                end
            end
            cnt_clr = ($urandom_range(0, 15) == 0);
            apply();
            @(negedge clk);
            gr = pick(rq, m_prd);
            gw = pick(wq, m_pwr);
            check("rand_rd_grant", DW'(bus.rd_grant), DW'(onehot(gr)));
            check("rand_wr_grant", DW'(bus.wr_grant), DW'(onehot(gw)));
            check("rand_cnt", DW'(contention_cnt), DW'(m_cnt));
            if (gr >= 0) begin
                e.oh = onehot(gr);
                e.stamp = cyc;
                e.known = 1'b0;
                e.data = '0;
                if (gw >= 0 && wa[gw] == ra[gr]) begin
                    e.known = 1'b1;
                    e.data = wd[gw];
                end else if (m_mem.exists(int'(ra[gr]))) begin
                    e.known = 1'b1;
                    e.data = m_mem[int'(ra[gr])];
                end
                sb.push_back(e);
                m_prd = (gr + 1) % N;
            end
            if (gw >= 0) begin
                m_mem[int'(wa[gw])] = wd[gw];
                m_pwr = (gw + 1) % N;
            end
            ci = (count_set(rq) >= 2 || count_set(wq) >= 2) ? 1 : 0;
            if (cnt_clr) m_cnt = 0;
            else if (ci == 1 && m_cnt < CMAX) m_cnt = m_cnt + 1;
            @(posedge clk); #1;
        end
        idle();
        cnt_clr = 1'b0;
        @(posedge clk); #3;
        mon_en = 1'b0;
        check("scoreboard_drained", DW'(sb.size()), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
